// File: rtl/serdiv_arbiter.sv
// Round-robin arbiter that shares one serial divider between NR_REQ requesters,
// tracks the owner of the single in-flight op and routes its result or flush back.
module serdiv_arbiter #(
    parameter int unsigned NR_REQ  = 2,
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned ID_BITS = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NR_REQ-1:0]                req_valid_i,
    output logic [NR_REQ-1:0]                req_ready_o,
    input  logic [NR_REQ-1:0][ID_BITS-1:0]   req_id_i,
    input  logic [NR_REQ-1:0][WIDTH-1:0]     req_op_a_i,
    input  logic [NR_REQ-1:0][WIDTH-1:0]     req_op_b_i,
    input  logic [NR_REQ-1:0][1:0]           req_opcode_i,
    input  logic [NR_REQ-1:0]                req_flush_i,
    output logic [NR_REQ-1:0]                resp_valid_o,
    input  logic [NR_REQ-1:0]                resp_ready_i,
    output logic [ID_BITS-1:0]               resp_id_o,
    output logic [WIDTH-1:0]                 resp_res_o,
    output logic                             div_in_vld_o,
    input  logic                             div_in_rdy_i,
    output logic [ID_BITS-1:0]               div_id_o,
    output logic [WIDTH-1:0]                 div_op_a_o,
    output logic [WIDTH-1:0]                 div_op_b_o,
    output logic [1:0]                       div_opcode_o,
    output logic                             div_flush_o,
    input  logic                             div_out_vld_i,
    output logic                             div_out_rdy_o,
    input  logic [ID_BITS-1:0]               div_id_i,
    input  logic [WIDTH-1:0]                 div_res_i
);

    localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e               state_r;
    state_e               state_nxt_s;
    logic [IDX_W-1:0]     rr_r;
    logic [IDX_W-1:0]     rr_nxt_s;
    logic [IDX_W-1:0]     owner_r;
    logic [IDX_W-1:0]     owner_nxt_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic                 grant_vld_s;
    logic                 grant_allow_s;
    logic                 owner_flush_s;
    logic                 resp_hs_s;
    logic [NR_REQ-1:0]    elig_s;
    logic [IDX_W:0]       wrap_s;
    logic [IDX_W:0]       rr_inc_s;
    logic                 hit_s;

    // Round-robin search for the first eligible requester at/after the pointer;
    // gated by reset so nothing is issued while the divider is held in reset.
    always_comb begin
        elig_s        = req_valid_i & ~req_flush_i;
        grant_allow_s = rst_ni && (state_r == IDLE) && div_in_rdy_i;
        grant_idx_s   = {IDX_W{1'b0}};
        grant_vld_s   = 1'b0;
        wrap_s        = {(IDX_W+1){1'b0}};
        hit_s         = 1'b0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            wrap_s      = {1'b0, rr_r} + (IDX_W+1)'(i);
            wrap_s      = (wrap_s >= (IDX_W+1)'(NR_REQ)) ? wrap_s - (IDX_W+1)'(NR_REQ) : wrap_s;
            hit_s       = grant_allow_s && !grant_vld_s && elig_s[wrap_s[IDX_W-1:0]];
            grant_idx_s = hit_s ? wrap_s[IDX_W-1:0] : grant_idx_s;
            grant_vld_s = grant_vld_s | hit_s;
        end
    end

    // State, round-robin pointer and owner registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            rr_r    <= {IDX_W{1'b0}};
            owner_r <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            rr_r    <= rr_nxt_s;
            owner_r <= owner_nxt_s;
        end
    end

    // Next-state logic: owner flush takes priority over a result handshake.
    always_comb begin
        owner_flush_s = req_flush_i[owner_r];
        resp_hs_s     = div_out_vld_i & resp_ready_i[owner_r];
        rr_inc_s      = {1'b0, grant_idx_s} + {{IDX_W{1'b0}}, 1'b1};
        state_nxt_s   = state_r;
        rr_nxt_s      = rr_r;
        owner_nxt_s   = owner_r;
        case (state_r)
            IDLE: begin
                if (grant_vld_s) begin
                    state_nxt_s = BUSY;
                    owner_nxt_s = grant_idx_s;
                    rr_nxt_s    = (rr_inc_s >= (IDX_W+1)'(NR_REQ)) ? {IDX_W{1'b0}} : rr_inc_s[IDX_W-1:0];
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (owner_flush_s || resp_hs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output logic: operand mux and handshakes are combinational (zero added latency).
    always_comb begin
        req_ready_o   = {NR_REQ{1'b0}};
        resp_valid_o  = {NR_REQ{1'b0}};
        div_in_vld_o  = 1'b0;
        div_out_rdy_o = 1'b0;
        div_flush_o   = 1'b0;
        div_id_o      = req_id_i[grant_idx_s];
        div_op_a_o    = req_op_a_i[grant_idx_s];
        div_op_b_o    = req_op_b_i[grant_idx_s];
        div_opcode_o  = req_opcode_i[grant_idx_s];
        resp_id_o     = div_id_i;
        resp_res_o    = div_res_i;
        case (state_r)
            IDLE: begin
                div_in_vld_o             = grant_vld_s;
                req_ready_o[grant_idx_s] = grant_vld_s;
            end
            BUSY: begin
                div_flush_o           = owner_flush_s;
                resp_valid_o[owner_r] = div_out_vld_i & ~owner_flush_s;
                div_out_rdy_o         = resp_ready_i[owner_r] & ~owner_flush_s;
            end
            default: begin
                div_in_vld_o = 1'b0;
            end
        endcase
    end

    serdiv_arbiter_chk #(.NR_REQ(NR_REQ)) u_chk (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .busy         (state_r == BUSY),
        .req_ready    (req_ready_o),
        .resp_valid   (resp_valid_o),
        .div_in_vld   (div_in_vld_o)
    );

endmodule

// Protocol checks on the arbiter's handshake outputs.
module serdiv_arbiter_chk #(
    parameter int unsigned NR_REQ = 2
) (
    input logic              clk_i,
    input logic              rst_ni,
    input logic              busy,
    input logic [NR_REQ-1:0] req_ready,
    input logic [NR_REQ-1:0] resp_valid,
    input logic              div_in_vld
);
    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready));
    a_resp_onehot0:  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(resp_valid));
    a_no_issue_busy: assert property (@(posedge clk_i) disable iff (!rst_ni) busy |-> !div_in_vld);
    a_no_b2b_issue:  assert property (@(posedge clk_i) disable iff (!rst_ni) div_in_vld |=> !div_in_vld);
endmodule

// File: tb/tb_serdiv_arbiter.sv
// Self-checking bench: a behavioural divider plus a round-robin/ownership reference
// model predict every handshake and result; directed scenarios then random traffic.
module tb_serdiv_arbiter;
    localparam int NR  = 2;
    localparam int W   = 64;
    localparam int IDB = 3;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]           req_valid, req_ready, req_flush, resp_valid, resp_ready;
    logic [NR-1:0][IDB-1:0]  req_id;
    logic [NR-1:0][W-1:0]    req_op_a, req_op_b;
    logic [NR-1:0][1:0]      req_opc;
    logic [IDB-1:0]          resp_id, div_id_out, div_id_in;
    logic [W-1:0]            resp_res, div_op_a, div_op_b, div_res_in;
    logic [1:0]              div_opcode;
    logic                    div_in_vld, div_in_rdy, div_flush, div_out_vld, div_out_rdy;

    serdiv_arbiter #(.NR_REQ(NR), .WIDTH(W), .ID_BITS(IDB)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_id_i(req_id),
        .req_op_a_i(req_op_a), .req_op_b_i(req_op_b), .req_opcode_i(req_opc),
        .req_flush_i(req_flush), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_id_o(resp_id), .resp_res_o(resp_res),
        .div_in_vld_o(div_in_vld), .div_in_rdy_i(div_in_rdy), .div_id_o(div_id_out),
        .div_op_a_o(div_op_a), .div_op_b_o(div_op_b), .div_opcode_o(div_opcode),
        .div_flush_o(div_flush), .div_out_vld_i(div_out_vld), .div_out_rdy_o(div_out_rdy),
        .div_id_i(div_id_in), .div_res_i(div_res_in)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RISC-V division semantics, including divide-by-zero and signed overflow.
    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
        logic signed [63:0] sa, sb;
        logic ovf;
        sa = a; sb = b;
        ovf = (a == MINV) && (b == ALL1);
        case (op)
            2'd0: return (b == 64'd0) ? ALL1 : a / b;
            2'd1: return (b == 64'd0) ? ALL1 : (ovf ? MINV : 64'(sa / sb));
            2'd2: return (b == 64'd0) ? a : a % b;
            2'd3: return (b == 64'd0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
            default: return 64'd0;
        endcase
    endfunction

    bit m_busy; int m_owner, m_rr;
    logic [63:0] m_res; logic [IDB-1:0] m_id;
    int dv_st = 0, dv_cnt = 0, lat_lo = 1, lat_hi = 4;
    logic [IDB-1:0] dv_id = '0; logic [63:0] dv_res = 64'd0;
    logic [NR-1:0] s_ready, s_rvalid;
    logic s_in_vld, s_flush, s_ordy;
    logic [63:0] s_res, s_a, s_b; logic [IDB-1:0] s_rid, s_did; logic [1:0] s_opc;
    int obs_grant;

    task automatic set_op(input int r, input logic [IDB-1:0] id, input logic [63:0] a,
                          input logic [63:0] b, input logic [1:0] opc);
        req_id[r] = id; req_op_a[r] = a; req_op_b[r] = b; req_opc[r] = opc;
    endtask

    // One clock: entered just after a negedge with requester inputs set, leaves at next negedge.
    task automatic cycle();
        int g; bit fl; logic [NR-1:0] elig, e_ready, e_rvalid; logic e_flush, e_ordy;
        div_in_rdy = (dv_st == 0); div_out_vld = (dv_st == 2);
        div_id_in = dv_id; div_res_in = dv_res;
        #1;
        g = -1; fl = 1'b0; e_ready = '0; e_rvalid = '0; e_flush = 1'b0; e_ordy = 1'b0;
        if (!m_busy) begin
            elig = req_valid & ~req_flush;
            if (div_in_rdy)
                for (int k = 0; k < NR; k++)
                    if (g < 0 && elig[(m_rr + k) % NR]) g = (m_rr + k) % NR;
            if (g >= 0) e_ready[g] = 1'b1;
        end else begin
            fl = req_flush[m_owner];
            e_flush = fl;
            e_rvalid[m_owner] = div_out_vld & ~fl;
            e_ordy = resp_ready[m_owner] & ~fl;
        end
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("div_in_vld", 64'(div_in_vld), (g >= 0) ? 64'd1 : 64'd0);
        chk("resp_valid", 64'(resp_valid), 64'(e_rvalid));
        chk("div_flush", 64'(div_flush), 64'(e_flush));
        chk("div_out_rdy", 64'(div_out_rdy), 64'(e_ordy));
        if (g >= 0) begin
            chk("div_op_a", div_op_a, req_op_a[g]);
            chk("div_op_b", div_op_b, req_op_b[g]);
            chk("div_id", 64'(div_id_out), 64'(req_id[g]));
            chk("div_opcode", 64'(div_opcode), 64'(req_opc[g]));
        end
        if (e_rvalid != '0) begin
            chk("resp_id", 64'(resp_id), 64'(m_id));
            chk("resp_res", resp_res, m_res);
        end
        s_ready = req_ready; s_rvalid = resp_valid; s_in_vld = div_in_vld; s_flush = div_flush;
        s_ordy = div_out_rdy; s_res = resp_res; s_rid = resp_id; s_a = div_op_a; s_b = div_op_b;
        s_did = div_id_out; s_opc = div_opcode;
        obs_grant = -1;
        for (int k = 0; k < NR; k++) if (req_ready[k] && obs_grant < 0) obs_grant = k;
        @(posedge clk);
        if (g >= 0) begin
            m_busy = 1'b1; m_owner = g; m_rr = (g + 1) % NR;
            m_res = ref_div(req_op_a[g], req_op_b[g], req_opc[g]); m_id = req_id[g];
        end else if (m_busy && (fl || (div_out_vld && resp_ready[m_owner]))) begin
            m_busy = 1'b0;
        end
        if (s_flush) dv_st = 0;
        else case (dv_st)
            0: if (s_in_vld) begin
                   dv_id = s_did; dv_res = ref_div(s_a, s_b, s_opc);
                   dv_cnt = $urandom_range(lat_hi, lat_lo); dv_st = 1;
               end
            1: begin dv_cnt--; if (dv_cnt <= 0) dv_st = 2; end
            2: if (s_ordy) dv_st = 0;
            default: dv_st = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic wait_resp(input int r, input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            cycle();
            got = s_rvalid[r];
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; req_valid = '1; req_flush = '0; resp_ready = '1;
        dv_st = 0; m_busy = 1'b0; m_rr = 0; div_in_rdy = 1'b1; div_out_vld = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_div_in_vld", 64'(div_in_vld), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_div_flush", 64'(div_flush), 64'd0);
        chk("rst_div_out_rdy", 64'(div_out_rdy), 64'd0);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 4))
            0: return 64'd0;
            1: return ALL1;
            2: return MINV;
            3: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit got; int first, second, n; int cnt [NR];
        for (int r = 0; r < NR; r++) set_op(r, '0, 64'd0, 64'd1, 2'd0);
        do_reset();

        // 100/7 signed div on requester 0
        set_op(0, 3'd3, 64'd100, 64'd7, 2'd1); req_valid = 2'b01;
        cycle();
        chk("t1_ready", 64'(s_ready), 64'd1);
        chk("t1_in_vld", 64'(s_in_vld), 64'd1);
        req_valid = '0;
        wait_resp(0, 20, got);
        chk("t1_seen", 64'(got), 64'd1);
        chk("t1_id", 64'(s_rid), 64'd3);
        chk("t1_res", s_res, 64'd14);

        // Fairness with both requesters continuously valid
        do_reset();
        set_op(0, 3'd1, 64'd50, 64'd5, 2'd0); set_op(1, 3'd2, 64'd81, 64'd9, 2'd0);
        req_valid = 2'b11; first = -1; second = -1; n = 0;
        for (int r = 0; r < NR; r++) cnt[r] = 0;
        for (int i = 0; i < 200 && n < 8; i++) begin
            cycle();
            if (obs_grant >= 0) begin
                if (n == 0) first = obs_grant;
                if (n == 1) second = obs_grant;
                cnt[obs_grant]++; n++;
            end
        end
        chk("t2_first", 64'(first), 64'd0);
        chk("t2_second", 64'(second), 64'd1);
        chk("t2_cnt0", 64'(cnt[0]), 64'd4);
        chk("t2_cnt1", 64'(cnt[1]), 64'd4);

        // Held response: rem -7/2 on requester 1 with back-pressure
        do_reset();
        set_op(1, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'd3); req_valid = 2'b10; resp_ready = 2'b01;
        cycle();
        chk("t3_grant", 64'(obs_grant), 64'd1);
        set_op(0, 3'd5, 64'd20, 64'd4, 2'd0); req_valid = 2'b01;
        wait_resp(1, 20, got);
        chk("t3_seen", 64'(got), 64'd1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t3_hold_valid", 64'(s_rvalid), 64'd2);
            chk("t3_hold_res", s_res, ALL1);
            chk("t3_no_grant", 64'(s_ready), 64'd0);
        end
        resp_ready = 2'b11;
        cycle();
        chk("t3_handshake", 64'(s_ordy), 64'd1);
        cycle();
        chk("t3_next_grant", 64'(obs_grant), 64'd0);
        req_valid = '0;

        // Owner flush mid-op, then requester 1 gets the divider
        do_reset();
        lat_lo = 8; lat_hi = 8;
        set_op(0, 3'd5, MINV, 64'd3, 2'd0); req_valid = 2'b01;
        cycle();
        chk("t4_grant0", 64'(obs_grant), 64'd0);
        req_valid = '0; cycle(); cycle();
        set_op(1, 3'd6, 64'd100, 64'd7, 2'd2); req_valid = 2'b10; req_flush = 2'b01;
        cycle();
        chk("t4_flush", 64'(s_flush), 64'd1);
        chk("t4_no_resp", 64'(s_rvalid), 64'd0);
        chk("t4_no_grant", 64'(s_ready), 64'd0);
        req_flush = '0;
        cycle();
        chk("t4_grant1", 64'(obs_grant), 64'd1);
        chk("t4_flush_pulse", 64'(s_flush), 64'd0);
        req_valid = '0;
        wait_resp(1, 20, got);
        chk("t4_seen", 64'(got), 64'd1);
        chk("t4_res", s_res, 64'd2);
        chk("t4_id", 64'(s_rid), 64'd6);

        // Non-owner flush must not disturb the owner
        do_reset();
        lat_lo = 5; lat_hi = 5;
        set_op(0, 3'd1, 64'd42, 64'd6, 2'd1); req_valid = 2'b01;
        cycle();
        req_valid = '0; cycle();
        req_flush = 2'b10;
        cycle();
        chk("t5_no_flush", 64'(s_flush), 64'd0);
        req_flush = '0;
        wait_resp(0, 20, got);
        chk("t5_seen", 64'(got), 64'd1);
        chk("t5_res", s_res, 64'd7);
        chk("t5_id", 64'(s_rid), 64'd1);

        // Asynchronous reset while a result is pending
        do_reset();
        lat_lo = 2; lat_hi = 2;
        set_op(0, 3'd2, 64'd9, 64'd3, 2'd1); req_valid = 2'b01; resp_ready = 2'b00;
        cycle();
        req_valid = '0;
        wait_resp(0, 20, got);
        chk("t6_seen", 64'(got), 64'd1);
        req_valid = 2'b10; resp_ready = 2'b11; rst_ni = 1'b0;
        #1;
        chk("t6_resp_valid", 64'(resp_valid), 64'd0);
        chk("t6_out_rdy", 64'(div_out_rdy), 64'd0);
        chk("t6_in_vld", 64'(div_in_vld), 64'd0);
        chk("t6_ready", 64'(req_ready), 64'd0);
        chk("t6_flush", 64'(div_flush), 64'd0);
        div_in_rdy = 1'b1; div_out_vld = 1'b0;
        #1;
        chk("t6_rst_no_grant", 64'(req_ready), 64'd0);
        chk("t6_rst_no_issue", 64'(div_in_vld), 64'd0);
        m_busy = 1'b0; m_rr = 0; dv_st = 0; req_valid = '0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        set_op(0, 3'd7, 64'd1, 64'd0, 2'd1); req_valid = 2'b01;
        cycle();
        chk("t6_grant", 64'(obs_grant), 64'd0);
        req_valid = '0;
        wait_resp(0, 20, got);
        chk("t6_seen2", 64'(got), 64'd1);
        chk("t6_res", s_res, ALL1);
        chk("t6_id", 64'(s_rid), 64'd7);

        // Random traffic against the reference model
        do_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < NR; r++) begin
                set_op(r, IDB'($urandom), rnd_opnd(), rnd_opnd(), 2'($urandom));
                req_valid[r]  = 1'($urandom);
                req_flush[r]  = ($urandom_range(0, 7) == 0);
                resp_ready[r] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
